// File: rtl/chip_top.sv
// 4x4 8-bit matrix-multiply accelerator with a byte-wide host command interface.
// The host fills an input memory, snapshots it into a register file, multiplies, then reads C back.
module chip_top #(
    parameter int LOAD_CYCLES = 5,
    parameter int MM_CYCLES   = 12,
    parameter int ACC_W       = 18
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       en,
    input  logic [6:0] AUX,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       INTERRUPT_PIN,
    output logic       READ_LED,
    output logic       WRITE_LED,
    output logic       LOAD_LED,
    output logic       MATMUL_LED
);

    typedef enum logic [1:0] {IDLE, LOADING, COMPUTING, DONE} state_t;

    state_t state, state_next;

    logic [2:0] reg_select;
    logic [1:0] idx;
    logic       mode_write, mode_load, mode_read, mode_mm;

    logic [7:0]       mem   [8][4];
    logic [7:0]       rf    [8][4];
    logic [ACC_W-1:0] acc   [4][4];
    logic [ACC_W-1:0] c_res [4][4];
    logic [3:0]       cnt;
    logic [1:0]       k_sel;
    logic             load_last, mm_last, mac_active;

    assign reg_select = AUX[6:4];
    assign idx        = AUX[3:2];
    assign mode_write =  AUX[0] & ~AUX[1];
    assign mode_load  = ~AUX[0] &  AUX[1];
    assign mode_read  =  AUX[0] &  AUX[1];
    assign mode_mm    = ~AUX[0] & ~AUX[1];

    // cnt is 1 on the start edge, so the finishing edge is reached when cnt == N-1
    assign load_last  = (cnt == 4'(LOAD_CYCLES - 1));
    assign mm_last    = (cnt == 4'(MM_CYCLES - 1));
    assign mac_active = (cnt != 4'd0) && (cnt <= 4'd4);
    assign k_sel      = cnt[1:0] - 2'd1;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en && mode_load) begin
                    state_next = LOADING;
                end else if (en && mode_mm) begin
                    state_next = COMPUTING;
                end
            end
            LOADING:   if (load_last) state_next = DONE;
            COMPUTING: if (mm_last) state_next = DONE;
            DONE:      if (!en) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Host LEDs are gated by clear so they stay dark while reset is held
    always_comb begin
        INTERRUPT_PIN = (state == DONE);
        LOAD_LED      = (state == LOADING);
        MATMUL_LED    = (state == COMPUTING);
        WRITE_LED     = clear & (state == IDLE) & en & mode_write;
        READ_LED      = clear & (state == IDLE) & en & mode_read;
    end

    // One k step per edge across all 16 outputs; C is only replaced when the run completes
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int r = 0; r < 8; r++) begin
                for (int k = 0; k < 4; k++) begin
                    mem[r][k] <= 8'd0;
                    rf[r][k]  <= 8'd0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    acc[i][j]   <= '0;
                    c_res[i][j] <= '0;
                end
            end
            cnt      <= 4'd0;
            data_out <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        if (mode_write) begin
                            mem[reg_select][idx] <= data_in;
                        end else if (mode_read) begin
                            data_out <= reg_select[2] ? 8'd0 : c_res[reg_select[1:0]][idx][7:0];
                        end else if (mode_load) begin
                            cnt <= 4'd1;
                            for (int r = 0; r < 8; r++) begin
                                for (int k = 0; k < 4; k++) begin
                                    rf[r][k] <= mem[r][k];
                                end
                            end
                        end else begin
                            cnt <= 4'd1;
                            for (int i = 0; i < 4; i++) begin
                                for (int j = 0; j < 4; j++) begin
                                    acc[i][j] <= '0;
                                end
                            end
                        end
                    end
                end
                LOADING: begin
                    cnt <= cnt + 4'd1;
                end
                COMPUTING: begin
                    cnt <= cnt + 4'd1;
                    for (int i = 0; i < 4; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            if (mac_active) begin
                                acc[i][j] <= acc[i][j]
                                           + ACC_W'(rf[i][k_sel]) * ACC_W'(rf[4+j][k_sel]);
                            end
                            if (mm_last) begin
                                c_res[i][j] <= acc[i][j];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip_top.sv
// Randomized self-checking bench for chip_top against a plain-arithmetic matrix model.
module tb_chip_top;

    logic       clk = 1'b0;
    logic       clear;
    logic       en;
    logic [6:0] aux;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       int_pin, read_led, write_led, load_led, matmul_led;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_m [8][4];
    logic [7:0] rf_m  [8][4];
    int         c_m   [4][4];

    always #5 clk = ~clk;

    chip_top dut (
        .clk          (clk),
        .clear        (clear),
        .en           (en),
        .AUX          (aux),
        .data_in      (data_in),
        .data_out     (data_out),
        .INTERRUPT_PIN(int_pin),
        .READ_LED     (read_led),
        .WRITE_LED    (write_led),
        .LOAD_LED     (load_led),
        .MATMUL_LED   (matmul_led)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                mem_m[r][k] = 8'd0;
                rf_m[r][k]  = 8'd0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                c_m[i][j] = 0;
            end
        end
    endfunction

    function automatic void modelMatmul();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                c_m[i][j] = 0;
                for (int k = 0; k < 4; k++) begin
                    c_m[i][j] += int'(rf_m[i][k]) * int'(rf_m[4+j][k]);
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [6:0] a, input logic [7:0] d);
        en      = e;
        aux     = a;
        data_in = d;
    endtask

    task automatic doWrite(input logic [2:0] r, input logic [1:0] k, input logic [7:0] d);
        applyStimulus(1'b1, {r, k, 2'b01}, d);
        #1;
        checkOutput("write_led", 32'(write_led), 32'd1);
        tick();
        mem_m[r][k] = d;
        applyStimulus(1'b0, 7'd0, 8'd0);
    endtask

    task automatic writeRow(input logic [2:0] r, input logic [31:0] bytes);
        for (int k = 0; k < 4; k++) begin
            doWrite(r, 2'(k), bytes[31-8*k -: 8]);
        end
    endtask

    task automatic doRead(input string tag, input logic [2:0] r, input logic [1:0] k);
        int expv;
        applyStimulus(1'b1, {r, k, 2'b11}, 8'h00);
        tick();
        applyStimulus(1'b0, 7'd0, 8'd0);
        expv = r[2] ? 0 : (c_m[r[1:0]][k] & 255);
        checkOutput(tag, 32'(data_out), 32'(expv));
    endtask

    task automatic readAll(input string tag);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                doRead(tag, 3'(i), 2'(j));
            end
        end
    endtask

    // Issues LOAD or MATMUL, counts edges to the interrupt and completes the handshake
    task automatic runOp(input bit is_load, input bit hold_en, input bit inject_write);
        int edges;
        applyStimulus(1'b1, is_load ? 7'b0000010 : 7'b0000000, 8'h00);
        tick();
        edges = 1;
        checkOutput(is_load ? "load_led" : "matmul_led",
                    32'(is_load ? load_led : matmul_led), 32'd1);
        if (!hold_en) applyStimulus(1'b0, 7'd0, 8'd0);
        if (inject_write) begin
            applyStimulus(1'b1, 7'b0000001, 8'hEE);
            tick();
            edges++;
            applyStimulus(1'b0, 7'd0, 8'd0);
        end
        while (int_pin !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checkOutput(is_load ? "load_edges" : "mm_edges", 32'(edges),
                    32'(is_load ? 5 : 12));
        if (is_load) begin
            for (int r = 0; r < 8; r++) begin
                for (int k = 0; k < 4; k++) begin
                    rf_m[r][k] = mem_m[r][k];
                end
            end
        end else begin
            modelMatmul();
        end
        if (hold_en) begin
            repeat (3) tick();
            checkOutput("int_held", 32'(int_pin), 32'd1);
            applyStimulus(1'b0, 7'd0, 8'd0);
        end
        tick();
        checkOutput("int_release", 32'(int_pin), 32'd0);
        checkOutput("leds_idle", 32'({read_led, write_led, load_led, matmul_led}), 32'd0);
    endtask

    task automatic pulseReset();
        #2 clear = 1'b0;
        #2 clear = 1'b1;
        modelReset();
        tick();
    endtask

    initial begin
        clear = 1'b1;
        applyStimulus(1'b0, 7'd0, 8'd0);
        modelReset();
        #2 clear = 1'b0;

        repeat (5) begin
            applyStimulus(1'($urandom), 7'($urandom), 8'($urandom));
            tick();
            checkOutput("rst_data_out", 32'(data_out), 32'd0);
            checkOutput("rst_int", 32'(int_pin), 32'd0);
            checkOutput("rst_leds", 32'({read_led, write_led, load_led, matmul_led}), 32'd0);
        end
        applyStimulus(1'b0, 7'd0, 8'd0);
        #2 clear = 1'b1;
        tick();
        doRead("rst_c23", 3'd2, 2'd3);

        $display("[TB] full flow");
        writeRow(3'd0, {8'd0, 8'd2, 8'd3, 8'd1});
        writeRow(3'd1, {8'd0, 8'd2, 8'd0, 8'd3});
        writeRow(3'd2, {8'd1, 8'd2, 8'd4, 8'd4});
        writeRow(3'd3, {8'd0, 8'd2, 8'd4, 8'd2});
        writeRow(3'd4, {8'd2, 8'd2, 8'd0, 8'd0});
        writeRow(3'd5, {8'd2, 8'd4, 8'd4, 8'd0});
        writeRow(3'd6, {8'd4, 8'd1, 8'd4, 8'd1});
        writeRow(3'd7, {8'd2, 8'd4, 8'd1, 8'd4});
        runOp(1'b1, 1'b0, 1'b0);
        runOp(1'b0, 1'b1, 1'b0);
        checkOutput("flow_c01_model", 32'(c_m[0][1]), 32'd20);
        readAll("flow_c");

        $display("[TB] ones flow and write during compute");
        pulseReset();
        for (int r = 0; r < 8; r++) writeRow(3'(r), {8'd1, 8'd2, 8'd3, 8'd4});
        runOp(1'b1, 1'b0, 1'b0);
        runOp(1'b0, 1'b0, 1'b1);
        readAll("ones_c");
        runOp(1'b1, 1'b0, 1'b0);
        runOp(1'b0, 1'b0, 1'b0);
        readAll("nowrite_c");

        $display("[TB] overflow and snapshot");
        for (int r = 0; r < 8; r++) writeRow(3'(r), 32'hFFFF_FFFF);
        runOp(1'b1, 1'b0, 1'b0);
        runOp(1'b0, 1'b0, 1'b0);
        checkOutput("ovf_model", 32'(c_m[3][3]), 32'd260100);
        readAll("ovf_c");
        for (int r = 0; r < 4; r++) writeRow(3'(r), $urandom);
        runOp(1'b0, 1'b0, 1'b0);
        readAll("snap_c");

        $display("[TB] async clear mid compute");
        applyStimulus(1'b1, 7'd0, 8'd0);
        tick();
        applyStimulus(1'b0, 7'd0, 8'd0);
        repeat (2) tick();
        checkOutput("mid_matmul_led", 32'(matmul_led), 32'd1);
        #2 clear = 1'b0;
        #1;
        checkOutput("abort_matmul_led", 32'(matmul_led), 32'd0);
        checkOutput("abort_int", 32'(int_pin), 32'd0);
        #2 clear = 1'b1;
        modelReset();
        tick();
        readAll("abort_c");

        $display("[TB] random rounds");
        repeat (3) begin
            for (int r = 0; r < 8; r++) writeRow(3'(r), $urandom);
            runOp(1'b1, 1'($urandom), 1'b0);
            for (int n = 0; n < 3; n++) doWrite(3'($urandom), 2'($urandom), 8'($urandom));
            runOp(1'b0, 1'($urandom), 1'b0);
            readAll("rand_c");
            doRead("rand_hi_sel", 3'(4 + $urandom_range(0, 3)), 2'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
